// File: rtl/song_note_sequencer.sv
// -----------------------------------------------------------------------------
// song_note_sequencer
//
// Producer side of the note-load handshake into composite_note_player. Walks
// a song held in an external synchronous ROM (address {song, index}, data one
// cycle later) and hands each {note, duration} word to the player with a
// one-cycle load_new_note strobe whenever the player reports it is available.
// A zero duration field marks the end of a song; the last index slot also
// ends the song, so the note index never wraps back onto note 0.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous reset, active low
//   play            1 = advance through the song, 0 = pause/hold
//   song            song select
//   available       player ready for its next note
//   rom_addr        registered song ROM address {song, index}
//   rom_data        ROM word {note, duration}, valid one cycle after rom_addr
//   next_song_note  registered {note, duration} presented to the player
//   load_new_note   registered one-cycle strobe, next_song_note valid while high
//   song_done       registered one-cycle pulse at end of song
//   note_index      index of the next note to fetch
// -----------------------------------------------------------------------------
module song_note_sequencer #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 9,
    parameter int IDX_W  = 5,
    parameter int SONG_W = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic [SONG_W-1:0]         song,
    input  logic                      available,
    output logic [SONG_W+IDX_W-1:0]   rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]   rom_data,
    output logic [NOTE_W+DUR_W-1:0]   next_song_note,
    output logic                      load_new_note,
    output logic                      song_done,
    output logic [IDX_W-1:0]          note_index
);

    localparam int WORD_W = NOTE_W + DUR_W;
    localparam int ADDR_W = SONG_W + IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_LOAD,
        S_HOLDOFF,
        S_WAIT_AVAIL,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0]   next_song_note_q, next_song_note_d;
    logic                load_new_note_q, load_new_note_d;
    logic                song_done_q, song_done_d;
    logic [IDX_W-1:0]    note_index_q, note_index_d;
    logic                last_q, last_d;
    logic                song_change;

    // A new song selection aborts any note in progress; IDLE and DONE ignore
    // it because nothing is in flight there.
    assign song_change = (state_q != S_IDLE) && (state_q != S_DONE) && (song != song_q);

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d          = state_q;
        song_d           = song_q;
        rom_addr_d       = rom_addr_q;
        next_song_note_d = next_song_note_q;
        note_index_d     = note_index_q;
        last_d           = last_q;
        song_done_d      = 1'b0;

        if (song_change) begin
            state_d      = S_IDLE;
            note_index_d = '0;
            last_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    note_index_d = '0;
                    last_d       = 1'b0;
                    if (play && available) begin
                        song_d     = song;
                        rom_addr_d = {song, {IDX_W{1'b0}}};
                        state_d    = S_FETCH;
                    end
                end
                // Address was registered last cycle; the ROM samples it now.
                S_FETCH: state_d = S_CAPTURE;
                S_CAPTURE: begin
                    if (rom_data[DUR_W-1:0] == '0) begin
                        song_done_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        next_song_note_d = rom_data;
                        state_d          = S_LOAD;
                    end
                end
                S_LOAD: begin
                    note_index_d = note_index_q + IDX_W'(1);
                    // The top slot was just delivered; the wrapped index must
                    // never be fetched.
                    if (note_index_q == {IDX_W{1'b1}}) last_d = 1'b1;
                    state_d = S_HOLDOFF;
                end
                // Gives the player a cycle to drop available after the load.
                S_HOLDOFF: state_d = S_WAIT_AVAIL;
                S_WAIT_AVAIL: begin
                    if (last_q) begin
                        if (available) begin
                            song_done_d = 1'b1;
                            state_d     = S_DONE;
                        end
                    end else if (available && play) begin
                        rom_addr_d = {song_q, note_index_q};
                        state_d    = S_FETCH;
                    end
                end
                S_DONE: begin
                    if (!play) begin
                        state_d      = S_IDLE;
                        note_index_d = '0;
                        last_d       = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Strobe is decoded from the next state so it is high exactly while
        // the FSM sits in LOAD; an abort never lands in LOAD.
        load_new_note_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            song_q           <= '0;
            rom_addr_q       <= '0;
            next_song_note_q <= '0;
            load_new_note_q  <= 1'b0;
            song_done_q      <= 1'b0;
            note_index_q     <= '0;
            last_q           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q          <= state_d;
            song_q           <= song_d;
            rom_addr_q       <= rom_addr_d;
            next_song_note_q <= next_song_note_d;
            load_new_note_q  <= load_new_note_d;
            song_done_q      <= song_done_d;
            note_index_q     <= note_index_d;
            last_q           <= last_d;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign next_song_note = next_song_note_q;
    assign load_new_note  = load_new_note_q;
    assign song_done      = song_done_q;
    assign note_index     = note_index_q;

endmodule

// File: tb/tb_song_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_note_sequencer
//
// Bench for song_note_sequencer. A behavioural synchronous ROM feeds the DUT;
// expected note words are queued when a song is started and a negedge monitor
// pops and compares one entry per load_new_note strobe. A table of single-note
// songs covers the basic load/end-marker path; hand-written sequences cover
// back-to-back throughput, pause, full song, song change and mid-load reset.
// -----------------------------------------------------------------------------
module tb_song_note_sequencer;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 9;
    localparam int IDX_W  = 5;
    localparam int SONG_W = 2;
    localparam int WORD_W = NOTE_W + DUR_W;
    localparam int ADDR_W = SONG_W + IDX_W;

    logic                clk;
    logic                reset;
    logic                play;
    logic [SONG_W-1:0]   song;
    logic                available;
    logic [ADDR_W-1:0]   rom_addr;
    logic [WORD_W-1:0]   rom_data;
    logic [WORD_W-1:0]   next_song_note;
    logic                load_new_note;
    logic                song_done;
    logic [IDX_W-1:0]    note_index;

    song_note_sequencer #(
        .NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W), .SONG_W(SONG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .play          (play),
        .song          (song),
        .available     (available),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .next_song_note(next_song_note),
        .load_new_note (load_new_note),
        .song_done     (song_done),
        .note_index    (note_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song ROM: data valid one cycle after the address.
    logic [WORD_W-1:0] rom [2**ADDR_W];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard and monitor state.
    logic [WORD_W-1:0] exp_q [$];
    int load_cyc_q [$];
    int idx_q [$];
    int load_cnt = 0;
    int done_cnt = 0;
    int last_load_cyc = 0;
    logic prev_load = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (prev_load) idx_q.push_back(int'(note_index));
            if (load_new_note) begin
                load_cnt      <= load_cnt + 1;
                last_load_cyc <= cyc;
                load_cyc_q.push_back(cyc);
                check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check("next_song_note", 32'(next_song_note), 32'(exp_q.pop_front()));
            end
            if (song_done) begin
                done_cnt <= done_cnt + 1;
                check("song_done_one_cycle", 32'(prev_done), 32'd0);
            end
            prev_load <= load_new_note;
            prev_done <= song_done;
        end else begin
            prev_load <= 1'b0;
            prev_done <= 1'b0;
        end
    end

    task automatic wait_until_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_load(input int budget, input string name);
        int l0;
        int k;
        l0 = load_cnt;
        k  = 0;
        while (load_cnt == l0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, 32'(load_cnt != l0), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [SONG_W-1:0] song;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
        int                exp_loads;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int c0;
        int l0;
        int d0;
        int lc;

        vecs[0] = '{song: 2'd1, note: 6'd10, dur: 9'd4,   exp_loads: 1};
        vecs[1] = '{song: 2'd2, note: 6'd63, dur: 9'd511, exp_loads: 1};
        vecs[2] = '{song: 2'd3, note: 6'd0,  dur: 9'd1,   exp_loads: 1};
        vecs[3] = '{song: 2'd0, note: 6'd5,  dur: 9'd0,   exp_loads: 0};

        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = '0;
        reset     = 1'b0;
        play      = 1'b0;
        available = 1'b1;
        song      = '0;

        // Reset state.
        idle_cycles(2);
        check("rst_rom_addr",       32'(rom_addr),       32'd0);
        check("rst_next_song_note", 32'(next_song_note), 32'd0);
        check("rst_load_new_note",  32'(load_new_note),  32'd0);
        check("rst_song_done",      32'(song_done),      32'd0);
        check("rst_note_index",     32'(note_index),     32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(2);

        // Single-note songs from the table; available drops after the load
        // and song_done must wait for it to return.
        for (int r = 0; r < 4; r++) begin
            rom[{vecs[r].song, 5'd0}] = {vecs[r].note, vecs[r].dur};
            rom[{vecs[r].song, 5'd1}] = '0;
            if (vecs[r].exp_loads != 0) exp_q.push_back({vecs[r].note, vecs[r].dur});
            l0 = load_cnt;
            d0 = done_cnt;
            @(posedge clk); #1;
            song = vecs[r].song;
            play = 1'b1;
            c0   = cyc;
            wait_until_cyc(c0 + 1);
            check("row_first_addr", 32'(rom_addr), 32'({vecs[r].song, 5'd0}));
            if (vecs[r].exp_loads != 0) begin
                wait_load(10, "row_load_seen");
                check("row_load_latency", 32'(last_load_cyc - c0), 32'd3);
                available = 1'b0;
                idle_cycles(6);
                check("row_done_waits_avail", 32'(done_cnt - d0), 32'd0);
                check("row_no_fetch_unavail", 32'(rom_addr), 32'({vecs[r].song, 5'd0}));
                available = 1'b1;
            end
            wait_done(20, "row_done_seen");
            idle_cycles(5);
            check("row_load_count", 32'(load_cnt - l0), 32'(vecs[r].exp_loads));
            check("row_done_once",  32'(done_cnt - d0), 32'd1);
            check("row_hold_in_done", 32'(rom_addr), 32'({vecs[r].song, 5'(vecs[r].exp_loads)}));
            play = 1'b0;
            idle_cycles(3);
        end

        // Back-to-back: three notes, available held high.
        for (int i = 0; i < 3; i++) begin
            rom[{2'd2, 5'(i)}] = {6'(20 + i), 9'd1};
            exp_q.push_back({6'(20 + i), 9'd1});
        end
        rom[{2'd2, 5'd3}] = '0;
        load_cyc_q.delete();
        idx_q.delete();
        l0 = load_cnt;
        @(posedge clk); #1;
        song = 2'd2;
        play = 1'b1;
        c0   = cyc;
        wait_done(60, "b2b_done_seen");
        check("b2b_load_count", 32'(load_cnt - l0), 32'd3);
        check("b2b_first_latency", 32'(load_cyc_q[0] - c0), 32'd3);
        check("b2b_gap_1", 32'(load_cyc_q[1] - load_cyc_q[0]), 32'd5);
        check("b2b_gap_2", 32'(load_cyc_q[2] - load_cyc_q[1]), 32'd5);
        check("b2b_idx_1", 32'(idx_q[0]), 32'd1);
        check("b2b_idx_2", 32'(idx_q[1]), 32'd2);
        check("b2b_idx_3", 32'(idx_q[2]), 32'd3);
        play = 1'b0;
        idle_cycles(3);

        // Pause in WAIT_AVAIL with available high.
        rom[{2'd3, 5'd0}] = {6'd7, 9'd3};
        rom[{2'd3, 5'd1}] = {6'd8, 9'd6};
        rom[{2'd3, 5'd2}] = '0;
        exp_q.push_back({6'd7, 9'd3});
        exp_q.push_back({6'd8, 9'd6});
        @(posedge clk); #1;
        song = 2'd3;
        play = 1'b1;
        wait_load(10, "pause_first_load");
        play = 1'b0;
        l0   = load_cnt;
        idle_cycles(6);
        check("pause_no_load", 32'(load_cnt - l0), 32'd0);
        check("pause_no_fetch", 32'(rom_addr), 32'({2'd3, 5'd0}));
        @(posedge clk); #1;
        play = 1'b1;
        c0   = cyc;
        wait_load(10, "pause_resume_load");
        check("pause_resume_latency", 32'(last_load_cyc - c0), 32'd3);
        wait_done(20, "pause_done_seen");
        play = 1'b0;
        idle_cycles(3);

        // Full song: every slot holds a note, no end marker.
        for (int i = 0; i < 2**IDX_W; i++) begin
            rom[{2'd1, 5'(i)}] = {6'(i + 1), 9'(i + 1)};
            exp_q.push_back({6'(i + 1), 9'(i + 1)});
        end
        l0 = load_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        song = 2'd1;
        play = 1'b1;
        wait_done(400, "full_done_seen");
        idle_cycles(10);
        check("full_load_count", 32'(load_cnt - l0), 32'd32);
        check("full_done_once", 32'(done_cnt - d0), 32'd1);
        check("full_no_wrap_addr", 32'(rom_addr), 32'({2'd1, 5'd31}));
        check("full_index_wrapped", 32'(note_index), 32'd0);
        play = 1'b0;
        idle_cycles(3);

        // Song change 2 -> 3 while in HOLDOFF.
        rom[{2'd2, 5'd0}] = {6'd11, 9'd2};
        rom[{2'd2, 5'd1}] = {6'd12, 9'd2};
        rom[{2'd2, 5'd2}] = '0;
        exp_q.push_back({6'd11, 9'd2});
        @(posedge clk); #1;
        song = 2'd2;
        play = 1'b1;
        wait_load(10, "chg_first_load");
        lc = last_load_cyc;
        @(posedge clk); #1;
        song = 2'd3;
        play = 1'b0;
        d0   = done_cnt;
        l0   = load_cnt;
        wait_until_cyc(lc + 2);
        check("chg_index_zero", 32'(note_index), 32'd0);
        check("chg_note_kept", 32'(next_song_note), 32'({6'd11, 9'd2}));
        check("chg_no_strobe", 32'(load_new_note), 32'd0);
        idle_cycles(4);
        check("chg_no_done", 32'(done_cnt - d0), 32'd0);
        check("chg_no_load", 32'(load_cnt - l0), 32'd0);
        exp_q.push_back({6'd7, 9'd3});
        exp_q.push_back({6'd8, 9'd6});
        @(posedge clk); #1;
        play = 1'b1;
        c0   = cyc;
        wait_until_cyc(c0 + 1);
        check("chg_restart_addr", 32'(rom_addr), 32'({2'd3, 5'd0}));
        wait_done(40, "chg_done_seen");
        check("chg_new_song_loads", 32'(load_cnt - l0), 32'd2);
        play = 1'b0;
        idle_cycles(3);

        // Reset asserted during the LOAD cycle.
        exp_q.push_back({6'd1, 9'd1});
        @(posedge clk); #1;
        song = 2'd1;
        play = 1'b1;
        wait_load(10, "rst_mid_load_seen");
        #1;
        reset = 1'b0;
        #1;
        check("rstm_load_new_note",  32'(load_new_note),  32'd0);
        check("rstm_next_song_note", 32'(next_song_note), 32'd0);
        check("rstm_rom_addr",       32'(rom_addr),       32'd0);
        check("rstm_note_index",     32'(note_index),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        available = 1'b0;
        reset     = 1'b1;
        l0        = load_cnt;
        idle_cycles(6);
        check("rstm_no_strobe_after", 32'(load_cnt - l0), 32'd0);
        exp_q.push_back({6'd1, 9'd1});
        @(posedge clk); #1;
        available = 1'b1;
        c0        = cyc;
        wait_load(10, "rstm_restart_load");
        check("rstm_restart_latency", 32'(last_load_cyc - c0), 32'd3);
        play = 1'b0;
        idle_cycles(6);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/song_note_sequencer.md
Name: song_note_sequencer

Overview:
- Producer end of the note-load handshake into composite_note_player.
- Steps through a song stored in an external synchronous song ROM and presents one packed {note, duration} word per note.
- Pulses load_new_note each time the player reports it is available.
- Reports end-of-song, and aborts cleanly on a song change.

Parameters:
NOTE_W, 6, note code width (frequency ROM address).
DUR_W, 9, duration width in beats.
IDX_W, 5, note index width; 2**IDX_W note slots per song.
SONG_W, 2, song select width; ROM address is {song, index}.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
play  in  1  1 = advance through song; 0 = pause/hold.
song  in  SONG_W  song select.
available  in  1  player ready for next note (player's available output).
rom_addr  out  SONG_W+IDX_W  song ROM address, registered.
rom_data  in  NOTE_W+DUR_W  ROM word {note, duration}; valid 1 cycle after rom_addr.
next_song_note  out  NOTE_W+DUR_W  registered {note, duration} to player.
load_new_note  out  1  registered one-cycle strobe; next_song_note valid while high.
song_done  out  1  registered one-cycle pulse at end of song.
note_index  out  IDX_W  index of next note to fetch.

Behaviour:
- Reset (reset==0, async): state IDLE; rom_addr, next_song_note, note_index = 0; load_new_note, song_done = 0; song_q = 0.
- Outputs are registered; each is decoded from the next-state logic.
- States: IDLE, FETCH, CAPTURE, LOAD, HOLDOFF, WAIT_AVAIL, DONE.
- IDLE:
  - note_index = 0.
  - If play & available: latch song_q <= song, drive rom_addr <= {song, 0}, go to FETCH.
- FETCH: address is settling in the ROM; go to CAPTURE unconditionally.
- CAPTURE: rom_data is valid this cycle.
  - If duration field == 0 (end marker): song_done = 1 for one cycle, go to DONE; next_song_note is unchanged.
  - Else: next_song_note <= rom_data, go to LOAD.
- LOAD:
  - load_new_note = 1 for exactly this one cycle.
  - note_index <= note_index + 1.
  - If note_index == 2**IDX_W-1 before increment: set an internal last flag.
  - Go to HOLDOFF.
- HOLDOFF: one-cycle guard so the player's available can deassert after accepting the load; go to WAIT_AVAIL.
- WAIT_AVAIL:
  - If last flag: wait for available, then pulse song_done and go to DONE. No wrap to index 0.
  - Else if available & play: rom_addr <= {song_q, note_index}, go to FETCH.
  - Otherwise hold.
- DONE: hold until play == 0, then go to IDLE (index 0, last flag cleared). song_done fires only once per song.
- Pause: play == 0 stalls only the IDLE and WAIT_AVAIL exits. FETCH, CAPTURE, LOAD and HOLDOFF always complete, so a load already in flight is delivered.
- Song change: if song != song_q in any state other than IDLE or DONE:
  - Next state is IDLE; note_index = 0.
  - load_new_note is forced 0 that cycle; no song_done.
  - next_song_note keeps its last value.
- Throughput: one note per 5 cycles minimum (WAIT_AVAIL→FETCH→CAPTURE→LOAD→HOLDOFF→WAIT_AVAIL) when available is already high.
- Latency: play rising in IDLE with available high gives load_new_note exactly 3 cycles later.
- Width rules:
  - note_index increments modulo 2**IDX_W; wrap is never used as a valid address (last flag).
  - next_song_note packs {note[NOTE_W-1:0], duration[DUR_W-1:0]}, matching the player's split.
- Reset asserted mid-operation returns everything to the reset values immediately; no partial strobe is emitted after release.

Test Plan:
- Single note: song=1, ROM[{1,0}]={6'd10, 9'd4}, ROM[{1,1}] duration=0; available=1, play rises at cycle 0 -> rom_addr=0x20 at cycle 1; load_new_note high at cycle 3 with next_song_note={10,4}; after available re-rises, song_done pulses once; state stays DONE until play=0.
- Back-to-back: 3 notes of duration 1, available held high -> load_new_note pulses exactly 5 cycles apart; note_index reads 1, 2, 3 after each.
- Pause: play dropped while in WAIT_AVAIL with available=1 -> no fetch or load while paused; play restored -> next load 3 cycles later carrying ROM[{song,1}].
- Full song: 32 non-zero entries, no end marker -> 32 loads, then song_done after the 32nd note completes; no 33rd load; rom_addr never wraps to {song,0}.
- Song change: song switched 2→3 in HOLDOFF -> IDLE next cycle, note_index=0, no song_done; the next play starts at rom_addr={3,0}.
- Reset mid-LOAD: reset=0 during the load cycle -> load_new_note=0, next_song_note=0 and rom_addr=0 immediately (async); after release, no strobe until play & available.
